disp_page_scheduler: RTL

//  Drives Disp_sel of the display output mux: walks the 19 display pages (0..18) in auto-dwell or manual mode.

---
 rtl/disp_pkg.sv | 42 ++++
 rtl/disp_page_scheduler_if.sv | 36 +++
 rtl/disp_dwell_timer.sv | 32 +++
 rtl/disp_page_scheduler.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display page scheduler: page count, index width,
// FSM state encoding, named page indices and small index helpers.
package disp_pkg;

    localparam int NUM_PAGES = 19;
    localparam int SEL_W     = 5;

    // Named page indices
    localparam logic [SEL_W-1:0] PAGE_FIRST = SEL_W'(0);
    localparam logic [SEL_W-1:0] PAGE_LAST  = SEL_W'(NUM_PAGES - 1);
    localparam logic [SEL_W-1:0] PAGE_HOME  = PAGE_FIRST;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SEARCH = 2'd2
    } state_t;

    // Neighbouring page index with wrap-around in either direction.
    function automatic logic [SEL_W-1:0] step_page(input logic [SEL_W-1:0] idx,
                                                   input logic fwd);
        logic [SEL_W-1:0] r;
        if (fwd) begin
            r = (idx >= PAGE_LAST) ? PAGE_FIRST : idx + SEL_W'(1);
        end else begin
            r = (idx == PAGE_FIRST || idx > PAGE_LAST) ? PAGE_LAST : idx - SEL_W'(1);
        end
        return r;
    endfunction

    // Mask lookup that reads as disabled for any index outside the page range.
    function automatic logic page_enabled(input logic [NUM_PAGES-1:0] mask,
                                          input logic [SEL_W-1:0] idx);
        logic en;
        en = 1'b0;
        for (int i = 0; i < NUM_PAGES; i++) begin
            if (idx == SEL_W'(i)) en = mask[i];
        end
        return en;
    endfunction

endpackage

// File: rtl/disp_page_scheduler_if.sv
// Signal bundle between the button/console side (master) and the page
// scheduler (slave).
//
// Jump handshake: the master raises jump_valid with jump_page stable and
// holds both until it sees jump_ack high. jump_ack is a one-cycle pulse in the
// cycle the request is consumed (valid and ack high together = transfer);
// jump_err is meaningful only in that cycle. The master must drop jump_valid
// (or present a new request) after the ack cycle.
interface disp_page_scheduler_if;

    logic                            EN;
    logic                            auto_mode;
    logic                            btn_next;
    logic                            btn_prev;
    logic [disp_pkg::NUM_PAGES-1:0]  page_mask;
    logic                            jump_valid;
    logic [disp_pkg::SEL_W-1:0]      jump_page;

    logic [disp_pkg::SEL_W-1:0]      Disp_sel;
    logic                            sel_valid;
    logic                            busy;
    logic                            page_changed;
    logic                            jump_ack;
    logic                            jump_err;

    modport master (
        output EN, auto_mode, btn_next, btn_prev, page_mask, jump_valid, jump_page,
        input  Disp_sel, sel_valid, busy, page_changed, jump_ack, jump_err
    );

    modport slave (
        input  EN, auto_mode, btn_next, btn_prev, page_mask, jump_valid, jump_page,
        output Disp_sel, sel_valid, busy, page_changed, jump_ack, jump_err
    );

endinterface

// File: rtl/disp_dwell_timer.sv
// Dwell counter for auto mode: counts enabled cycles and raises a one-cycle
// expire pulse on the cycle the count sits at DWELL_CYCLES-1. Holding enable
// low freezes the count so a pending expiry is not lost.
module disp_dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expire = enable && !clear && (count == LAST_CNT);

    // Count register: clear wins, wraps to zero on expiry, holds when disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_page_scheduler.sv
// Display page scheduler: picks the page index driven to the display mux.
// Walks enabled pages on dwell expiry (auto mode) or next/prev pulses, and
// serves direct jump requests. A search steps one candidate per cycle.
module disp_page_scheduler
    import disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    disp_page_scheduler_if.slave  bus,
    output state_t                state_dbg
);

    state_t           state, state_n;
    logic             fwd, fwd_n;
    logic [SEL_W-1:0] cursor, cursor_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic             changed_q, changed_n;

    logic             in_show;
    logic             step_req;
    logic             jump_take;
    logic             jump_ok;
    logic             step_take;
    logic             cur_enabled;
    logic [SEL_W-1:0] cand;
    logic             cand_enabled;
    logic             dwell_clear;
    logic             dwell_en;
    logic             dwell_expire;

    // Event decode; kept outside the FSM block so the timer enable does not
    // loop back through it.
    assign in_show      = bus.EN && (state == ST_SHOW);
    assign step_req     = bus.btn_next ^ bus.btn_prev;
    assign jump_ok      = (bus.jump_page <= PAGE_LAST) && page_enabled(bus.page_mask, bus.jump_page);
    assign jump_take    = in_show && bus.jump_valid;
    assign step_take    = in_show && !bus.jump_valid && step_req;
    assign cur_enabled  = page_enabled(bus.page_mask, sel_q);
    assign cand         = step_page(cursor, fwd);
    assign cand_enabled = page_enabled(bus.page_mask, cand);

    // Dwell only runs while showing in auto mode; higher-priority events
    // freeze it for that cycle, and a real page change restarts it.
    assign dwell_en    = in_show && bus.auto_mode && !bus.jump_valid && !step_req;
    assign dwell_clear = !(in_show && bus.auto_mode)
                         || (jump_take && jump_ok && (bus.jump_page != sel_q));

    disp_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clear  (dwell_clear),
        .enable (dwell_en),
        .expire (dwell_expire)
    );

    // Outputs: status decoded from state, handshake straight from the decode.
    assign bus.Disp_sel     = sel_q;
    assign bus.sel_valid    = (state == ST_SHOW) && cur_enabled;
    assign bus.busy         = (state == ST_SEARCH);
    assign bus.page_changed = changed_q;
    assign bus.jump_ack     = jump_take;
    assign bus.jump_err     = jump_take && !jump_ok;
    assign state_dbg        = state;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            fwd       <= 1'b1;
            cursor    <= PAGE_LAST;
            sel_q     <= PAGE_HOME;
            changed_q <= 1'b0;
        end else begin
            state     <= state_n;
            fwd       <= fwd_n;
            cursor    <= cursor_n;
            sel_q     <= sel_n;
            changed_q <= changed_n;
        end
    end

    // Next-state logic: EN low forces IDLE; SHOW arbitrates jump > step >
    // (current page masked out or dwell expiry); SEARCH tests one candidate.
    always_comb begin
        state_n   = state;
        fwd_n     = fwd;
        cursor_n  = cursor;
        sel_n     = sel_q;
        changed_n = 1'b0;
        if (!bus.EN) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Start just before page 0 so page 0 is the first candidate.
                    state_n  = ST_SEARCH;
                    fwd_n    = 1'b1;
                    cursor_n = PAGE_LAST;
                end
                ST_SHOW: begin
                    if (jump_take) begin
                        if (jump_ok) begin
                            sel_n     = bus.jump_page;
                            changed_n = (bus.jump_page != sel_q);
                        end
                    end else if (step_take) begin
                        state_n  = ST_SEARCH;
                        fwd_n    = bus.btn_next;
                        cursor_n = sel_q;
                    end else if (!cur_enabled || dwell_expire) begin
                        state_n  = ST_SEARCH;
                        fwd_n    = 1'b1;
                        cursor_n = sel_q;
                    end
                end
                ST_SEARCH: begin
                    // Coming back round to the start page is just another
                    // candidate; with an empty mask the scan keeps going.
                    if (cand_enabled) begin
                        sel_n     = cand;
                        changed_n = (cand != sel_q);
                        state_n   = ST_SHOW;
                    end else begin
                        cursor_n = cand;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule
